coarse_ctrl_sequencer: RTL and testbench
========================================

// Module: coarse_ctrl_sequencer
// PURPOSE
//  Consumes the 32-bit software control word from the coarse_ctrl OPB register (user_data_out, user_clk domain).
//  Filters the word for stability, decodes its fields and edge-detects its control bits.
//  Schedules coarse-delay loads, either armed (applied on the next sync_in) or immediate.
//  Drives the coarse-delay stage with a registered delay value and a one-cycle load strobe.
// PARAMETERS
//  DELAY_W       16     width of coarse-delay field/output; 1..16
//  MAX_DELAY     1023   largest delay applied; larger requests clamp to this value
//  STABLE_CYCLES 3      consecutive identical samples required to accept a new ctrl_word; >=1
// PORTS
//  user_clk     in   1        single clock for all logic
//  user_rst     in   1        synchronous, active-high reset
//  ctrl_word    in   32       control word from coarse_ctrl register
//  sync_in      in   1        system sync pulse; one cycle wide
//  delay_out    out  DELAY_W  applied coarse delay, registered
//  load_pulse   out  1        one-cycle strobe, high in the cycle delay_out takes its new value
//  armed        out  1        high while a load waits for sync_in
//  load_count   out  16       number of loads performed; saturates at 16'hFFFF
//  clamp_flag   out  1        sticky: a requested delay exceeded MAX_DELAY
// BEHAVIOUR
//  Field map: [DELAY_W-1:0]=delay req, [16]=arm, [17]=immediate, [18]=clr_count; other bits ignored.
//  Reset: delay_out=0, load_pulse=0, armed=0, load_count=0, clamp_flag=0, accepted word=0, state=IDLE.
//  Stability filter:
//   - ctrl_word is registered every cycle; a run counter counts consecutive identical samples.
//   - The accepted word updates on the edge on which the STABLE_CYCLES-th identical sample is taken.
//   - A change restarts the count; glitches shorter than STABLE_CYCLES never reach the accepted word.
//  Edge decode: compares the accepted word with its previous value; edges act on the next edge (1 cycle later).
//  A word already nonzero at reset release is treated as a fresh write, and its rising edges fire.
//  Clamp:
//   - On any edge that captures a request, req_eff = min(req, MAX_DELAY).
//   - If req > MAX_DELAY, clamp_flag is set.
//  FSM states: IDLE, ARMED, LOAD.
//   IDLE : arm rise -> capture req_eff into pending, go ARMED.
//          immediate rise -> capture req_eff, go LOAD.
//          sync_in is ignored.
//   ARMED: armed=1.
//          sync_in=1 -> LOAD.
//          immediate rise -> capture new req_eff, go LOAD; cancels the arm.
//          arm fall -> IDLE, no load.
//          arm re-rise -> recapture req_eff, stay ARMED.
//          A sync_in in the same cycle the arm edge is decoded does not fire; only a later sync_in does.
//          If sync_in coincides with an arm fall, the fall wins and no load occurs.
//   LOAD : one cycle, then unconditionally to IDLE.
//          delay_out <= pending, load_pulse=1, load_count increments (saturating).
//          Edges decoded during LOAD are held and processed in IDLE on the next cycle.
//  Latency:
//   - Immediate: ctrl_word stable from cycle 0 -> load_pulse in cycle STABLE_CYCLES+2.
//   - Armed: load_pulse comes 1 cycle after sync_in is sampled in ARMED.
//  clr_count rise: load_count=0 and clamp_flag=0.
//   - Wins over a simultaneous increment; the load itself still happens.
//   - Wins over a simultaneous clamp set.
//  armed is a registered decode of state==ARMED; load_pulse is never high two cycles in a row.
//  user_rst mid-ARMED or mid-LOAD: the pending load is discarded and all outputs return to reset values.
// TESTING
//  T1 With STABLE_CYCLES=3, ctrl_word 0x0002_0064 held from cycle 0 -> load_pulse only in cycle 5, delay_out=100, load_count=1.
//  T2 ctrl_word=0x0001_00C8, then sync_in 10 cycles later.
//     -> armed=1 until sync_in; load_pulse on the next cycle; delay_out=200.
//     -> An earlier sync_in pulse issued in IDLE produces no load.
//  T3 ctrl_word glitches to 0x0002_0005 for 2 cycles, then returns to 0.
//     -> No load; delay_out and load_count remain unchanged.
//  T4 Immediate request 0x0002_0800 (2048) -> delay_out=1023 and clamp_flag=1.
//     -> A later word 0x0004_0000 clears clamp_flag and load_count.
//  T5 Arm then clear arm before sync (arm fall), then sync_in -> no load, armed drops to 0 after the fall is decoded.
//  T6 Arm, then assert user_rst for 1 cycle while ARMED, then sync_in.
//     -> No load; all outputs are 0.
//     -> ctrl_word still reads 0x0001_00C8, so arm re-fires after STABLE_CYCLES.

Source files
------------

// File: rtl/coarse_ctrl_sequencer.sv
// Coarse-delay load sequencer: filters the software control word, decodes its
// control edges and drives the coarse-delay stage with armed or immediate loads.
module coarse_ctrl_sequencer #(
  parameter int DELAY_W       = 16,
  parameter int MAX_DELAY     = 1023,
  parameter int STABLE_CYCLES = 3
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        ctrl_word,
  input  logic               sync_in,
  output logic [DELAY_W-1:0] delay_out,
  output logic               load_pulse,
  output logic               armed,
  output logic [15:0]        load_count,
  output logic               clamp_flag
);

  localparam int RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [DELAY_W-1:0] MAX_D   = DELAY_W'(MAX_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [31:0]        sample_r, acc_r;
  logic [RUN_W-1:0]   run_r, run_next_s;
  logic [2:0]         prev_ctl_r;
  logic [DELAY_W-1:0] pending_r, req_s, req_eff_s;
  logic               accept_s, over_s, capture_s;
  logic               arm_rise_s, arm_fall_s, imm_rise_s, clr_rise_s;
  logic               held_arm_r, held_imm_r, arm_go_s, imm_go_s;

  // Run length of identical samples, saturating at the acceptance threshold
  always_comb begin
    run_next_s = RUN_W'(1);
    if (ctrl_word != sample_r) begin
      run_next_s = RUN_W'(1);
    end else if (run_r >= RUN_MAX) begin
      run_next_s = RUN_MAX;
    end else begin
      run_next_s = run_r + RUN_W'(1);
    end
    accept_s = (run_next_s == RUN_MAX);
  end

  // Stability filter and previous-control history for edge decode
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      sample_r   <= 32'd0;
      run_r      <= '0;
      acc_r      <= 32'd0;
      prev_ctl_r <= 3'd0;
    end else begin
      sample_r   <= ctrl_word;
      run_r      <= run_next_s;
      prev_ctl_r <= acc_r[18:16];
      if (accept_s) acc_r <= ctrl_word;
    end
  end

  assign arm_rise_s = acc_r[16] & ~prev_ctl_r[0];
  assign arm_fall_s = ~acc_r[16] & prev_ctl_r[0];
  assign imm_rise_s = acc_r[17] & ~prev_ctl_r[1];
  assign clr_rise_s = acc_r[18] & ~prev_ctl_r[2];
  assign arm_go_s   = arm_rise_s | held_arm_r;
  assign imm_go_s   = imm_rise_s | held_imm_r;

  // Clamp the requested delay; compare at full width so small DELAY_W stays safe
  always_comb begin
    req_s     = acc_r[DELAY_W-1:0];
    over_s    = ({{(32-DELAY_W){1'b0}}, req_s} > 32'(MAX_DELAY));
    req_eff_s = over_s ? MAX_D : req_s;
  end

  // Next-state decode; immediate beats arm, and an arm fall beats sync_in
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (imm_go_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_LOAD;
        end else if (arm_go_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (imm_rise_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_LOAD;
        end else if (arm_fall_s) begin
          state_next_s = ST_IDLE;
        end else if (arm_rise_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_ARMED;
        end else if (sync_in) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_LOAD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, pending request, held edges and registered outputs
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_r    <= ST_IDLE;
      pending_r  <= '0;
      held_arm_r <= 1'b0;
      held_imm_r <= 1'b0;
      delay_out  <= '0;
      load_pulse <= 1'b0;
      armed      <= 1'b0;
      load_count <= 16'd0;
      clamp_flag <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      held_arm_r <= (state_r == ST_LOAD) ? arm_rise_s : 1'b0;
      held_imm_r <= (state_r == ST_LOAD) ? imm_rise_s : 1'b0;
      load_pulse <= (state_r == ST_LOAD);
      armed      <= (state_next_s == ST_ARMED);
      if (capture_s) pending_r <= req_eff_s;
      if (state_r == ST_LOAD) delay_out <= pending_r;
      // Clear wins over both a same-cycle increment and a same-cycle clamp
      if (clr_rise_s) begin
        load_count <= 16'd0;
        clamp_flag <= 1'b0;
      end else begin
        if ((state_r == ST_LOAD) && (load_count != 16'hFFFF)) load_count <= load_count + 16'd1;
        if (capture_s && over_s) clamp_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coarse_ctrl_sequencer.sv
// Self-checking bench for coarse_ctrl_sequencer: per-scenario tasks plus a
// scoreboard of expected {load_count, delay_out} popped on every load_pulse.
module tb_coarse_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] ctrl_word = 32'd0;
  logic        sync_in = 1'b0;
  logic [15:0] delay_out;
  logic        load_pulse;
  logic        armed;
  logic [15:0] load_count;
  logic        clamp_flag;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_pulse = 1'b0;

  coarse_ctrl_sequencer #(.DELAY_W(16), .MAX_DELAY(1023), .STABLE_CYCLES(3)) dut (
    .user_clk  (clk),
    .user_rst  (user_rst),
    .ctrl_word (ctrl_word),
    .sync_in   (sync_in),
    .delay_out (delay_out),
    .load_pulse(load_pulse),
    .armed     (armed),
    .load_count(load_count),
    .clamp_flag(clamp_flag)
  );

  always #5 clk = ~clk;

  // Scoreboard: every load strobe must match the next expected {count, delay}
  always @(negedge clk) begin
    if (user_rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (load_pulse) begin
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL load_back_to_back load_pulse high two cycles in a row");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load got delay_out=%0d load_count=%0d, expected no load",
                   delay_out, load_count);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if ({load_count, delay_out} !== e) begin
            errors++;
            $display("FAIL load_value got count=%0d delay=%0d, expected count=%0d delay=%0d",
                     load_count, delay_out, e[31:16], e[15:0]);
          end
        end
      end
      prev_pulse = load_pulse;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    user_rst  = 1'b1;
    ctrl_word = 32'd0;
    sync_in   = 1'b0;
    tick(2);
    user_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending loads, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({delay_out, load_pulse, armed, load_count, clamp_flag} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got delay=%0d pulse=%0b armed=%0b count=%0d clamp=%0b, expected all 0",
               delay_out, load_pulse, armed, load_count, clamp_flag);
    end
  endtask

  task automatic test_immediate();
    do_reset();
    ctrl_word = 32'h0002_0064;
    exp_q.push_back({16'd1, 16'd100});
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (load_pulse !== (i == 5)) begin
        errors++;
        $display("FAIL imm_latency cycle %0d got load_pulse=%0b, expected %0b", i, load_pulse, (i == 5));
      end
    end
    wait_drain("imm");
    checks++;
    if (delay_out !== 16'd100 || load_count !== 16'd1) begin
      errors++;
      $display("FAIL imm_result got delay=%0d count=%0d, expected 100 1", delay_out, load_count);
    end
  endtask

  task automatic test_armed();
    do_reset();
    pulse_sync();
    ctrl_word = 32'h0001_00C8;
    tick(6);
    @(negedge clk);
    checks++;
    if (armed !== 1'b1 || load_count !== 16'd0) begin
      errors++;
      $display("FAIL armed_wait got armed=%0b count=%0d, expected 1 0", armed, load_count);
    end
    tick(3);
    exp_q.push_back({16'd1, 16'd200});
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    @(negedge clk);
    checks++;
    if (armed !== 1'b0 || load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL armed_after_sync got armed=%0b pulse=%0b, expected 0 0", armed, load_pulse);
    end
    wait_drain("armed");
    checks++;
    if (delay_out !== 16'd200) begin
      errors++;
      $display("FAIL armed_delay got %0d, expected 200", delay_out);
    end
  endtask

  task automatic test_glitch();
    ctrl_word = 32'd0;
    tick(6);
    ctrl_word = 32'h0002_0005;
    tick(2);
    ctrl_word = 32'd0;
    tick(10);
    @(negedge clk);
    checks++;
    if (delay_out !== 16'd200 || load_count !== 16'd1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL glitch got delay=%0d count=%0d armed=%0b, expected 200 1 0",
               delay_out, load_count, armed);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    ctrl_word = 32'h0002_0800;
    exp_q.push_back({16'd1, 16'd1023});
    wait_drain("clamp");
    @(negedge clk);
    checks++;
    if (delay_out !== 16'd1023 || clamp_flag !== 1'b1) begin
      errors++;
      $display("FAIL clamp_set got delay=%0d clamp=%0b, expected 1023 1", delay_out, clamp_flag);
    end
    ctrl_word = 32'h0004_0000;
    tick(8);
    @(negedge clk);
    checks++;
    if (clamp_flag !== 1'b0 || load_count !== 16'd0 || delay_out !== 16'd1023) begin
      errors++;
      $display("FAIL clr_count got clamp=%0b count=%0d delay=%0d, expected 0 0 1023",
               clamp_flag, load_count, delay_out);
    end
  endtask

  task automatic test_arm_cancel();
    do_reset();
    ctrl_word = 32'h0001_00C8;
    tick(6);
    @(negedge clk);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL cancel_armed got armed=%0b, expected 1", armed);
    end
    ctrl_word = 32'd0;
    tick(3);
    @(negedge clk);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL cancel_before_decode got armed=%0b, expected 1", armed);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL cancel_after_decode got armed=%0b, expected 0", armed);
    end
    pulse_sync();
    tick(5);
    @(negedge clk);
    checks++;
    if (load_count !== 16'd0 || delay_out !== 16'd0) begin
      errors++;
      $display("FAIL cancel_no_load got count=%0d delay=%0d, expected 0 0", load_count, delay_out);
    end
  endtask

  task automatic test_reset_armed();
    do_reset();
    ctrl_word = 32'h0001_00C8;
    tick(6);
    @(negedge clk);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL rst_armed_pre got armed=%0b, expected 1", armed);
    end
    user_rst = 1'b1;
    tick(1);
    user_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({delay_out, load_pulse, armed, load_count, clamp_flag} !== 35'd0) begin
      errors++;
      $display("FAIL rst_armed_outputs got delay=%0d pulse=%0b armed=%0b count=%0d clamp=%0b, expected all 0",
               delay_out, load_pulse, armed, load_count, clamp_flag);
    end
    pulse_sync();
    tick(6);
    @(negedge clk);
    checks++;
    if (armed !== 1'b1 || load_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_armed_refire got armed=%0b count=%0d, expected 1 0", armed, load_count);
    end
    exp_q.push_back({16'd1, 16'd200});
    pulse_sync();
    wait_drain("rst_armed");
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_immediate();
    test_armed();
    test_glitch();
    test_clamp();
    test_arm_cancel();
    test_reset_armed();
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
